clk_period_meter: RTL and testbench

Receive-side checker for the team's clock dividers. It samples a divided clock (clk_in) in the system clock domain and measures one full period of clk_in in system-clock cycles: high time, low time, total period and a duty check. It is used on-board and in benches to confirm divider ratio and 50% duty (±1 cycle for odd ratios).

---
 rtl/clk_period_meter.sv | 160 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures one full period of a divided clock in system-clock cycles.
// Reports high, low and total time plus a 50% duty check.
module clk_period_meter #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] period,
  output logic             duty_ok,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] L_TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WRISE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_wd;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic             w_rise;
  logic             w_fall;
  logic             w_wd_exp;
  logic             w_tmo;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_per;
  logic [CNT_W-1:0] w_diff;
  logic             w_duty;

  assign w_rise   = r_s2 & ~r_s3;
  assign w_fall   = ~r_s2 & r_s3;
  assign w_wd_exp = (r_wd >= L_TMO);

  assign w_sum  = {1'b0, r_hcnt} + {1'b0, r_lcnt};
  assign w_per  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_diff = (r_hcnt >= r_lcnt) ? (r_hcnt - r_lcnt)
                                     : (r_lcnt - r_hcnt);
  assign w_duty = (w_diff <= L_ONE);

  assign busy = (r_state == S_ARM)  || (r_state == S_WRISE) ||
                (r_state == S_HIGH) || (r_state == S_LOW);
  assign done = (r_state == S_DONE);

  always_comb begin
    w_state_nx = r_state;
    w_tmo      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_ARM;
      end
      S_ARM: begin
        if (!r_s2) begin
          w_state_nx = S_WRISE;
        end else if (w_wd_exp) begin
          w_state_nx = S_DONE;
          w_tmo      = 1'b1;
        end
      end
      S_WRISE: begin
        if (w_rise) begin
          w_state_nx = S_HIGH;
        end else if (w_wd_exp) begin
          w_state_nx = S_DONE;
          w_tmo      = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          w_state_nx = S_LOW;
        end else if (w_wd_exp) begin
          w_state_nx = S_DONE;
          w_tmo      = 1'b1;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_nx = S_DONE;
        end else if (w_wd_exp) begin
          w_state_nx = S_DONE;
          w_tmo      = 1'b1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_wd      <= '0;
      r_hcnt    <= '0;
      r_lcnt    <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      duty_ok   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s1    <= clk_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      // Any state change is an advancing edge and restarts the watchdog
      if (r_state != w_state_nx) begin
        r_wd <= '0;
      end else if (busy && (r_wd != '1)) begin
        r_wd <= r_wd + L_ONE;
      end
      if ((r_state == S_WRISE) && w_rise) begin
        r_hcnt <= L_ONE;
      end else if ((r_state == S_HIGH) && !w_fall && (r_hcnt != '1)) begin
        r_hcnt <= r_hcnt + L_ONE;
      end
      if ((r_state == S_HIGH) && w_fall) begin
        r_lcnt <= L_ONE;
      end else if ((r_state == S_LOW) && !w_rise && (r_lcnt != '1)) begin
        r_lcnt <= r_lcnt + L_ONE;
      end
      if ((w_state_nx == S_DONE) && (r_state != S_DONE)) begin
        if (w_tmo) begin
          high_time <= '0;
          low_time  <= '0;
          period    <= '0;
          duty_ok   <= 1'b0;
          timeout   <= 1'b1;
        end else begin
          high_time <= r_hcnt;
          low_time  <= r_lcnt;
          period    <= w_per;
          duty_ok   <= w_duty;
          timeout   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: directed divider ratios,
// timeout, ignored start and mid-measurement reset.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_in;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] high_time;
  logic [15:0] low_time;
  logic [15:0] period;
  logic        duty_ok;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] h;
    logic [15:0] l;
    logic [15:0] p;
    logic        d;
    logic        t;
  } exp_t;

  exp_t q[$];

  clk_period_meter #(
    .CNT_W  (16),
    .TIMEOUT(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_in   (clk_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .high_time(high_time),
    .low_time (low_time),
    .period   (period),
    .duty_ok  (duty_ok),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // clk_in generator: hi cycles high, lo cycles low, or stuck high
  int g_hi = 0;
  int g_lo = 0;
  bit g_stuck = 1'b0;
  int g_ph = 0;

  initial begin
    clk_in = 1'b0;
    forever begin
      @(negedge clk);
      if (g_stuck) begin
        clk_in = 1'b1;
      end else if (g_hi == 0) begin
        clk_in = 1'b0;
      end else begin
        g_ph = (g_ph + 1 >= g_hi + g_lo) ? 0 : g_ph + 1;
        clk_in = (g_ph < g_hi);
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp("high_time", high_time, e.h);
        cmp("low_time", low_time, e.l);
        cmp("period", period, e.p);
        cmp("duty_ok", duty_ok, e.d);
        cmp("timeout", timeout, e.t);
      end
    end
  end

  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < budget);
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_wait: got no done expected done within %0d", budget);
    end
  endtask

  task automatic wait_lvl(input logic v);
    int n;
    n = 0;
    while (clk_in !== v && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (clk_in !== v) begin
      n_vec++;
      n_err++;
      $display("FAIL clk_in_wait: got %0b expected %0b", clk_in, v);
    end
  endtask

  task automatic set_gen(input int hi, input int lo);
    g_stuck = 1'b0;
    g_hi = hi;
    g_lo = lo;
    repeat (12) @(posedge clk);
  endtask

  task automatic after_done;
    @(negedge clk);
    cmp("busy_after_done", busy, 0);
    cmp("done_single_cycle", done, 0);
  endtask

  task automatic measure(input int hi, input int lo,
                         input logic [15:0] eh, input logic [15:0] el,
                         input logic [15:0] ep, input logic ed);
    int c;
    set_gen(hi, lo);
    q.push_back('{eh, el, ep, ed, 1'b0});
    pulse_start();
    @(negedge clk);
    cmp("busy_after_start", busy, 1);
    wait_done(100, c);
    after_done();
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_high", high_time, 0);
    cmp("rst_low", low_time, 0);
    cmp("rst_period", period, 0);
    cmp("rst_duty", duty_ok, 0);
    cmp("rst_timeout", timeout, 0);

    measure(2, 2, 16'd2, 16'd2, 16'd4, 1'b1);
    measure(3, 2, 16'd3, 16'd2, 16'd5, 1'b1);
    measure(2, 1, 16'd2, 16'd1, 16'd3, 1'b1);
    measure(1, 1, 16'd1, 16'd1, 16'd2, 1'b1);
    measure(7, 3, 16'd7, 16'd3, 16'd10, 1'b0);

    g_stuck = 1'b1;
    repeat (5) @(posedge clk);
    q.push_back('{16'd0, 16'd0, 16'd0, 1'b0, 1'b1});
    pulse_start();
    wait_done(60, c);
    cmp("tmo_latency_in_18_25", (c >= 18 && c <= 25), 1);
    after_done();
    measure(2, 2, 16'd2, 16'd2, 16'd4, 1'b1);

    // Second start while in HIGH must be ignored
    set_gen(7, 3);
    q.push_back('{16'd7, 16'd3, 16'd10, 1'b0, 1'b0});
    wait_lvl(1'b1);
    wait_lvl(1'b0);
    pulse_start();
    wait_lvl(1'b1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cmp("busy_mid_high", busy, 1);
    wait_done(100, c);
    after_done();
    repeat (30) @(posedge clk);

    // Reset in LOW discards the measurement
    set_gen(3, 7);
    wait_lvl(1'b1);
    wait_lvl(1'b0);
    pulse_start();
    wait_lvl(1'b1);
    wait_lvl(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp("busy_mid_low", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("rstlow_busy", busy, 0);
    cmp("rstlow_done", done, 0);
    cmp("rstlow_high", high_time, 0);
    cmp("rstlow_low", low_time, 0);
    cmp("rstlow_period", period, 0);
    cmp("rstlow_duty", duty_ok, 0);
    repeat (40) @(posedge clk);
    cmp("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
